mem_access: RTL and testbench

Memory-access stage of the 64-bit in-order pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. For load/store instructions it drives the data-bus request, holds `Dwait` high until the access completes, and presents the aligned, extended load result. For non-memory instructions it passes the ALU result through. Its `Dwait` output is the stall input consumed by the MEM/WB register.

---
 rtl/mem_access.sv | 134 +++++++++++++
 tb/tb_mem_access.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-bus request per load/store, aligns and extends load data.
// Latency: 2 cycles with same-cycle data_ok, N+2 with N wait cycles; non-memory ops pass through combinationally.
// Backpressure: Dwait holds MEM/WB (and freezes EX/MEM) from the first request cycle through the data_ok cycle.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_msize,
    input  logic        ex_mem_unsigned,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    input  logic [63:0] ex_result,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        Dwait,
    output logic [63:0] mem_result,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [63:0] rdata_q;

    logic        is_mem;
    logic        is_load;
    logic        is_store;
    logic        aligned;
    logic        req_new;
    logic        req_active;
    logic [5:0]  lane_sh;
    logic [7:0]  strobe_base;
    logic [63:0] load_sh;
    logic [63:0] load_val;

    // Read+write together is illegal and falls back to a load.
    assign is_mem   = ex_valid & (ex_mem_read | ex_mem_write);
    assign is_load  = ex_mem_read;
    assign is_store = ex_mem_write & ~ex_mem_read;
    assign lane_sh  = {ex_addr[2:0], 3'b000};

    always_comb begin
        aligned = 1'b1;
        case (ex_msize)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (ex_addr[0] == 1'b0);
            2'd2:    aligned = (ex_addr[1:0] == 2'b00);
            default: aligned = (ex_addr[2:0] == 3'b000);
        endcase
    end

    assign misaligned = is_mem & ~aligned;
    assign req_new    = (state == IDLE) & is_mem & aligned;
    // Gated by reset so an in-flight request drops the moment reset asserts.
    assign req_active = reset & (req_new | (state == BUSY));
    assign dreq_valid = req_active;
    assign Dwait      = req_active;

    assign dreq_addr = ex_addr;
    assign dreq_size = {1'b0, ex_msize};
    assign dreq_data = ex_wdata << lane_sh;

    always_comb begin
        strobe_base = 8'h00;
        case (ex_msize)
            2'd0:    strobe_base = 8'h01;
            2'd1:    strobe_base = 8'h03;
            2'd2:    strobe_base = 8'h0F;
            default: strobe_base = 8'hFF;
        endcase
    end

    assign dreq_strobe = (is_mem & is_store) ? (strobe_base << ex_addr[2:0]) : 8'h00;

    assign load_sh = rdata_q >> lane_sh;

    always_comb begin
        load_val = load_sh;
        case (ex_msize)
            2'd0: load_val = ex_mem_unsigned ? {56'd0, load_sh[7:0]}
                                             : {{56{load_sh[7]}}, load_sh[7:0]};
            2'd1: load_val = ex_mem_unsigned ? {48'd0, load_sh[15:0]}
                                             : {{48{load_sh[15]}}, load_sh[15:0]};
            2'd2: load_val = ex_mem_unsigned ? {32'd0, load_sh[31:0]}
                                             : {{32{load_sh[31]}}, load_sh[31:0]};
            default: load_val = load_sh;
        endcase
    end

    always_comb begin
        mem_result = ex_result;
        if (misaligned)
            mem_result = 64'd0;
        else if (is_mem & is_load)
            mem_result = load_val;
    end

    // DONE always returns to IDLE so a frozen EX/MEM slot never issues twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rdata_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_new) begin
                        if (dresp_data_ok) begin
                            rdata_q <= dresp_data;
                            state   <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dresp_data_ok) begin
                        rdata_q <= dresp_data;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model checked every cycle plus literal expectations.
module tb_mem_access;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_msize;
    logic        ex_mem_unsigned;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [63:0] ex_result;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        Dwait;
    logic [63:0] mem_result;
    logic        misaligned;

    int n_vec = 0;
    int n_err = 0;

    mem_access dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_msize(ex_msize), .ex_mem_unsigned(ex_mem_unsigned),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .Dwait(Dwait), .mem_result(mem_result), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] extract(input logic [63:0] raw, input logic [2:0] off,
                                            input logic [1:0] ms, input logic uns);
        logic [63:0] sh;
        logic [63:0] mask;
        logic [63:0] v;
        int nb;
        sh = raw >> (8 * off);
        if (ms == 2'd3) return sh;
        nb   = 8 * (1 << ms);
        mask = (64'd1 << nb) - 64'd1;
        v    = sh & mask;
        if (!uns && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Model: a request is outstanding, or the access just finished (result-presentation cycle).
    logic        m_open = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_rdata = 64'd0;
    logic        m_mem, m_store, m_align, m_mis, m_req, m_res_ok;
    logic [7:0]  m_strobe;
    logic [63:0] m_data, m_res;

    always_comb begin
        m_mem    = ex_valid && (ex_mem_read || ex_mem_write);
        m_store  = m_mem && ex_mem_write && !ex_mem_read;
        m_align  = (ex_addr % (64'd1 << ex_msize)) == 64'd0;
        m_mis    = m_mem && !m_align;
        m_req    = reset && !m_done && (m_open || (m_mem && m_align));
        m_strobe = m_store ? 8'((((16'd1 << (1 << ex_msize)) - 16'd1) << ex_addr[2:0])) : 8'h00;
        m_data   = ex_wdata << (8 * ex_addr[2:0]);
        m_res_ok = 1'b1;
        m_res    = ex_result;
        if (m_mis)
            m_res = 64'd0;
        else if (!m_mem)
            m_res = ex_result;
        else if (m_done)
            m_res = m_store ? ex_result : extract(m_rdata, ex_addr[2:0], ex_msize, ex_mem_unsigned);
        else begin
            m_res_ok = 1'b0;
            m_res    = 64'd0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_open  <= 1'b0;
            m_done  <= 1'b0;
            m_rdata <= 64'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_req) begin
            if (dresp_data_ok) begin
                m_rdata <= dresp_data;
                m_done  <= 1'b1;
                m_open  <= 1'b0;
            end else begin
                m_open <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("dreq_valid", {63'd0, dreq_valid}, {63'd0, m_req});
        chk("Dwait", {63'd0, Dwait}, {63'd0, m_req});
        chk("misaligned", {63'd0, misaligned}, {63'd0, m_mis});
        chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, m_strobe});
        if (m_req) begin
            chk("dreq_addr", dreq_addr, ex_addr);
            chk("dreq_size", {61'd0, dreq_size}, {62'd0, ex_msize});
            chk("dreq_data", dreq_data, m_data);
        end
        if (m_res_ok) chk("mem_result", mem_result, m_res);
    end

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] ms,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] res);
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_msize = ms;
        ex_mem_unsigned = uns; ex_addr = a; ex_wdata = wd; ex_result = res;
    endtask

    // Runs one memory op (already on ex_*) with a fixed number of wait cycles, through its DONE cycle.
    task automatic mem_op(input int waits, input logic [63:0] rd, output int dw, output logic [63:0] res);
        dw = 0;
        for (int i = 0; i <= waits; i++) begin
            dresp_data_ok = (i == waits);
            dresp_data    = rd;
            @(negedge clk);
            if (Dwait) dw++;
            @(posedge clk);
            #1;
        end
        dresp_data_ok = 1'b0;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        if (Dwait) dw++;
        res = mem_result;
        @(posedge clk);
        #1;
    endtask

    int          dw;
    logic [63:0] res;

    initial begin
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
        set_op(0, 0, 0, 0, 0, 64'd0, 64'd0, 64'h55);
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_Dwait", {63'd0, Dwait}, 64'd0);
        chk("rst_misaligned", {63'd0, misaligned}, 64'd0);
        chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        chk("rst_mem_result", mem_result, 64'h55);

        // Signed byte load, two wait cycles.
        set_op(1, 1, 0, 2'd0, 0, 64'h8000_0003, 64'd0, 64'h77);
        mem_op(2, 64'h0000_0000_8000_0000, dw, res);
        chk("lb_dwait_cycles", 64'(dw), 64'd3);
        chk("lb_result", res, 64'hFFFF_FFFF_FFFF_FF80);

        // Half store, data_ok in the request cycle.
        set_op(1, 0, 1, 2'd1, 0, 64'h8000_0006, 64'h1234, 64'hABCD);
        #1;
        chk("sh_strobe", {56'd0, dreq_strobe}, 64'hC0);
        chk("sh_data", dreq_data, 64'h1234_0000_0000_0000);
        mem_op(0, 64'd0, dw, res);
        chk("sh_dwait_cycles", 64'(dw), 64'd1);
        chk("sh_result", res, 64'hABCD);

        // Unsigned word load, then back-to-back signed half and dword loads.
        set_op(1, 1, 0, 2'd2, 1, 64'h8000_0004, 64'd0, 64'd0);
        mem_op(1, 64'hDEAD_BEEF_0000_0000, dw, res);
        chk("lwu_result", res, 64'h0000_0000_DEAD_BEEF);
        chk("lwu_dwait_cycles", 64'(dw), 64'd2);
        set_op(1, 1, 0, 2'd1, 0, 64'h8000_0002, 64'd0, 64'd0);
        mem_op(0, 64'h0000_0000_8001_0000, dw, res);
        chk("lh_result", res, 64'hFFFF_FFFF_FFFF_8001);
        set_op(1, 1, 0, 2'd3, 1, 64'h8000_0008, 64'd0, 64'd0);
        mem_op(3, 64'hF123_4567_89AB_CDEF, dw, res);
        chk("ld_result", res, 64'hF123_4567_89AB_CDEF);
        chk("ld_dwait_cycles", 64'(dw), 64'd4);

        // Byte store at lane 5.
        set_op(1, 0, 1, 2'd0, 0, 64'h8000_0005, 64'hAB, 64'h11);
        #1;
        chk("sb_strobe", {56'd0, dreq_strobe}, 64'h20);
        chk("sb_data", dreq_data, 64'h0000_AB00_0000_0000);
        mem_op(1, 64'd0, dw, res);
        chk("sb_result", res, 64'h11);

        // Misaligned dword load: no request, result forced to zero.
        set_op(1, 1, 0, 2'd3, 0, 64'h8000_0004, 64'd0, 64'h99);
        #1;
        chk("mis_flag", {63'd0, misaligned}, 64'd1);
        chk("mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("mis_Dwait", {63'd0, Dwait}, 64'd0);
        chk("mis_result", mem_result, 64'd0);
        @(posedge clk);
        #1;
        chk("mis_hold_Dwait", {63'd0, Dwait}, 64'd0);

        // ALU pass-through and a bubble carrying mem_read.
        set_op(1, 0, 0, 2'd0, 0, 64'h8000_0001, 64'd0, 64'h42);
        #1;
        chk("alu_result", mem_result, 64'h42);
        chk("alu_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        @(posedge clk);
        #1;
        set_op(0, 1, 0, 2'd2, 0, 64'h8000_0000, 64'd0, 64'h5);
        #1;
        chk("bub_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("bub_Dwait", {63'd0, Dwait}, 64'd0);
        @(posedge clk);
        #1;

        // Reset pulled mid-BUSY, then a stray data_ok.
        set_op(1, 1, 0, 2'd2, 0, 64'h8000_0010, 64'd0, 64'd0);
        dresp_data_ok = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstb_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rstb_Dwait", {63'd0, Dwait}, 64'd0);
        set_op(0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 64'h7);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        chk("stray_ok_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("stray_ok_result", mem_result, 64'h7);
        @(posedge clk);
        #1;
        dresp_data_ok = 1'b0;
        set_op(1, 1, 0, 2'd2, 0, 64'h8000_0010, 64'd0, 64'd0);
        mem_op(0, 64'h0000_0000_8000_0000, dw, res);
        chk("post_rst_dwait_cycles", 64'(dw), 64'd1);
        chk("post_rst_result", res, 64'hFFFF_FFFF_8000_0000);

        set_op(0, 0, 0, 2'd0, 0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
